// File: rtl/vga_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_stream_tx
// Brief    : Parametrised VGA timing generator that drains {r,g,b} pixels from
//            a valid/ready stream framed by a start-of-frame flag.
// Revision : 1.0 - initial release
// ============================================================================
module vga_stream_tx #(
    parameter int RD     = 5,
    parameter int GD     = 6,
    parameter int BD     = 5,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter logic [RD+GD+BD-1:0] UNDER_RGB = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RD+GD+BD-1:0]   s_data,
    input  logic                  s_valid,
    input  logic                  s_sof,
    output logic                  s_ready,
    output logic [RD-1:0]         R,
    output logic [GD-1:0]         G,
    output logic [BD-1:0]         B,
    output logic                  HSync,
    output logic                  VSync,
    output logic                  de,
    output logic                  locked,
    output logic [15:0]           under_cnt,
    output logic [7:0]            desync_cnt
);

    localparam int c_W     = RD + GD + BD;
    localparam int c_H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int c_HW    = $clog2(c_H_TOT);
    localparam int c_VW    = $clog2(c_V_TOT);

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOT - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACT);
    localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACT + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOT - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACT);
    localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACT + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACT + V_FP + V_SYNC);

    localparam logic [1:0] c_ST_SEEK   = 2'd0;
    localparam logic [1:0] c_ST_ARMED  = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;

    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_W-1:0]  r_pix;
    logic            r_de;
    logic            r_hs;
    logic            r_vs;
    logic [15:0]     r_under;
    logic [7:0]      r_desync;

    logic            w_active;
    logic            w_origin;
    logic            w_hs_on;
    logic            w_vs_on;
    logic            w_ready;
    logic            w_de_nxt;
    logic [c_W-1:0]  w_pix_nxt;
    logic            w_under_inc;
    logic            w_desync_inc;

    assign w_active = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_origin = (r_h == '0) && (r_v == '0);
    assign w_hs_on  = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    assign w_vs_on  = (r_v >= c_VS_BEG) && (r_v < c_VS_END);

    // Free-running raster position; restarts at (0,0) on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_SEEK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_de_nxt     = 1'b0;
        w_pix_nxt    = '0;
        w_under_inc  = 1'b0;
        w_desync_inc = 1'b0;
        case (r_state)
            c_ST_SEEK: begin
                // The SOF beat is left on the bus for ARMED to take at (0,0).
                w_ready = ~(s_valid & s_sof);
                if (s_valid && s_sof) begin
                    w_state_nxt = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (w_origin) begin
                    w_ready  = 1'b1;
                    w_de_nxt = 1'b1;
                    if (s_valid) begin
                        w_pix_nxt   = s_data;
                        w_state_nxt = c_ST_STREAM;
                    end else begin
                        w_pix_nxt   = UNDER_RGB;
                        w_under_inc = 1'b1;
                    end
                end
            end
            c_ST_STREAM: begin
                if (w_active) begin
                    w_de_nxt = 1'b1;
                    w_ready  = ~(s_sof & s_valid & ~w_origin);
                    if (!s_valid) begin
                        w_pix_nxt   = UNDER_RGB;
                        w_under_inc = 1'b1;
                    end else if (s_sof && !w_origin) begin
                        // Early SOF: keep it and re-align at the next frame start.
                        w_pix_nxt    = UNDER_RGB;
                        w_desync_inc = 1'b1;
                        w_state_nxt  = c_ST_ARMED;
                    end else if (!s_sof && w_origin) begin
                        w_pix_nxt    = UNDER_RGB;
                        w_desync_inc = 1'b1;
                        w_state_nxt  = c_ST_SEEK;
                    end else begin
                        w_pix_nxt = s_data;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_SEEK;
            end
        endcase
    end

    // Single output register stage: pins lag the raster position by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix    <= '0;
            r_de     <= 1'b0;
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_under  <= '0;
            r_desync <= '0;
        end else begin
            r_pix <= w_pix_nxt;
            r_de  <= w_de_nxt;
            r_hs  <= w_hs_on ? HS_POL : ~HS_POL;
            r_vs  <= w_vs_on ? VS_POL : ~VS_POL;
            if (w_under_inc && (r_under != 16'hFFFF)) begin
                r_under <= r_under + 16'd1;
            end
            if (w_desync_inc && (r_desync != 8'hFF)) begin
                r_desync <= r_desync + 8'd1;
            end
        end
    end

    assign s_ready    = w_ready & rst;
    assign R          = r_pix[c_W-1 -: RD];
    assign G          = r_pix[GD+BD-1 -: GD];
    assign B          = r_pix[BD-1:0];
    assign HSync      = r_hs;
    assign VSync      = r_vs;
    assign de         = r_de;
    assign locked     = (r_state == c_ST_STREAM);
    assign under_cnt  = r_under;
    assign desync_cnt = r_desync;

endmodule

`default_nettype wire

// File: tb/tb_vga_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_stream_tx
// Brief    : Directed self-checking bench for vga_stream_tx on three timings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_stream_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // clock edges since reset release = raster position
    int mk       = 0;   // next beat index of the mid-size source
    int tk       = 0;   // next beat index of the tiny source

    // mid-size: H 16/2/3/2 (23), V 6/1/2/1 (10), frame 230
    logic [15:0] m_data;  logic m_valid, m_sof, m_ready;
    logic [4:0] m_r; logic [5:0] m_g; logic [4:0] m_b;
    logic m_hs, m_vs, m_de, m_locked; logic [15:0] m_under; logic [7:0] m_desync;
    // tiny: H 4/1/2/1 (8), V 3/1/1/1 (6), frame 48, VSync active-high
    logic [15:0] t_data;  logic t_valid, t_sof, t_ready;
    logic [4:0] t_r; logic [5:0] t_g; logic [4:0] t_b;
    logic t_hs, t_vs, t_de, t_locked; logic [15:0] t_under; logic [7:0] t_desync;
    // long: H 64/1/1/1 (67), V 64/1/1/1 (67), frame 4489
    logic [15:0] l_data;  logic l_valid, l_sof, l_ready;
    logic [4:0] l_r; logic [5:0] l_g; logic [4:0] l_b;
    logic l_hs, l_vs, l_de, l_locked; logic [15:0] l_under; logic [7:0] l_desync;

    vga_stream_tx #(
        .H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .UNDER_RGB(16'hF81F)
    ) dut_m (
        .clk(clk), .rst(rst), .s_data(m_data), .s_valid(m_valid), .s_sof(m_sof),
        .s_ready(m_ready), .R(m_r), .G(m_g), .B(m_b), .HSync(m_hs), .VSync(m_vs),
        .de(m_de), .locked(m_locked), .under_cnt(m_under), .desync_cnt(m_desync)
    );

    vga_stream_tx #(
        .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .VS_POL(1'b1), .UNDER_RGB(16'h07E0)
    ) dut_t (
        .clk(clk), .rst(rst), .s_data(t_data), .s_valid(t_valid), .s_sof(t_sof),
        .s_ready(t_ready), .R(t_r), .G(t_g), .B(t_b), .HSync(t_hs), .VSync(t_vs),
        .de(t_de), .locked(t_locked), .under_cnt(t_under), .desync_cnt(t_desync)
    );

    vga_stream_tx #(
        .H_ACT(64), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACT(64), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_l (
        .clk(clk), .rst(rst), .s_data(l_data), .s_valid(l_valid), .s_sof(l_sof),
        .s_ready(l_ready), .R(l_r), .G(l_g), .B(l_b), .HSync(l_hs), .VSync(l_vs),
        .de(l_de), .locked(l_locked), .under_cnt(l_under), .desync_cnt(l_desync)
    );

    function automatic logic [15:0] pix(input int k);
        return 16'(k * 521 + 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic step_m(input bit en, output bit rdy);
        m_valid = en;
        m_data  = pix(mk);
        m_sof   = (mk % 96 == 0);
        #1;
        rdy = m_ready;
        tick();
        if (en && rdy) mk++;
    endtask

    task automatic step_t(input bit en, output bit rdy);
        t_valid = en;
        t_data  = pix(tk);
        t_sof   = (tk % 12 == 0);
        #1;
        rdy = t_ready;
        tick();
        if (en && rdy) tk++;
    endtask

    task automatic lock_m();
        bit rdy;
        do_reset();
        mk = 0;
        while (cyc <= 230) step_m(1'b1, rdy);
    endtask

    task automatic test_reset();
        m_valid = 1'b1; m_sof = 1'b0; m_data = 16'hFFFF;
        #3 rst = 1'b0;
        #1;
        checks++; if ({m_r, m_g, m_b} !== 16'h0) begin failures++; $display("FAIL reset_rgb: got %h want 0000", {m_r, m_g, m_b}); end
        checks++; if (m_hs !== 1'b1 || m_vs !== 1'b1) begin failures++; $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", m_hs, m_vs); end
        checks++; if (t_vs !== 1'b0) begin failures++; $display("FAIL reset_vs_pol: got %b want 0", t_vs); end
        checks++; if (m_de !== 1'b0 || m_locked !== 1'b0) begin failures++; $display("FAIL reset_de_lock: got de=%b locked=%b want 0 0", m_de, m_locked); end
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", m_ready); end
        checks++; if (m_under !== 16'h0 || m_desync !== 8'h0) begin failures++; $display("FAIL reset_cnt: got %h/%h want 0/0", m_under, m_desync); end
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_stream_default();
        bit rdy;
        int beats[3];
        int bad_rdy = 0, bad_hs = 0, bad_vs = 0, bad_de = 0, bad_pix = 0, bad_lock = 0;
        int hs_low = 0, vs_low = 0;
        do_reset();
        mk = 0;
        beats = '{0, 0, 0};
        for (int c = 0; c < 690; c++) begin
            int p, h, v, fr;
            bit act, e_de;
            logic [15:0] e_pix;
            p = c % 230; h = p % 23; v = p / 23; fr = c / 230;
            act = (h < 16) && (v < 6);
            step_m(1'b1, rdy);
            if (rdy !== ((fr >= 1) && act)) bad_rdy++;
            if (rdy) beats[fr]++;
            e_de  = (fr >= 1) && act;
            e_pix = e_de ? pix((fr - 1) * 96 + v * 16 + h) : 16'h0;
            if (m_hs !== !(h >= 18 && h < 21)) bad_hs++;
            if (m_vs !== !(v >= 7 && v < 9)) bad_vs++;
            if (m_de !== e_de) bad_de++;
            if ({m_r, m_g, m_b} !== e_pix) bad_pix++;
            if (m_locked !== (fr >= 1)) bad_lock++;
            if (fr == 2 && m_hs === 1'b0) hs_low++;
            if (fr == 2 && m_vs === 1'b0) vs_low++;
        end
        checks++; if (bad_rdy != 0) begin failures++; $display("FAIL stream_ready: bad_cycles=%0d want 0", bad_rdy); end
        checks++; if (bad_hs != 0) begin failures++; $display("FAIL stream_hsync: bad_cycles=%0d want 0", bad_hs); end
        checks++; if (bad_vs != 0) begin failures++; $display("FAIL stream_vsync: bad_cycles=%0d want 0", bad_vs); end
        checks++; if (bad_de != 0) begin failures++; $display("FAIL stream_de: bad_cycles=%0d want 0", bad_de); end
        checks++; if (bad_pix != 0) begin failures++; $display("FAIL stream_rgb: bad_cycles=%0d want 0", bad_pix); end
        checks++; if (bad_lock != 0) begin failures++; $display("FAIL stream_locked: bad_cycles=%0d want 0", bad_lock); end
        checks++; if (beats[0] != 0) begin failures++; $display("FAIL beats_frame0: got %0d want 0", beats[0]); end
        checks++; if (beats[1] != 96) begin failures++; $display("FAIL beats_frame1: got %0d want 96", beats[1]); end
        checks++; if (beats[2] != 96) begin failures++; $display("FAIL beats_frame2: got %0d want 96", beats[2]); end
        checks++; if (hs_low != 30) begin failures++; $display("FAIL hsync_low_clks: got %0d want 30", hs_low); end
        checks++; if (vs_low != 46) begin failures++; $display("FAIL vsync_low_clks: got %0d want 46", vs_low); end
        checks++; if (m_under !== 16'd0 || m_desync !== 8'd0) begin failures++; $display("FAIL stream_cnt: got %0d/%0d want 0/0", m_under, m_desync); end
    endtask

    task automatic test_underflow();
        bit rdy;
        lock_m();
        while (cyc < 281) step_m(1'b1, rdy);    // next edge is frame 1, v=2, h=5
        for (int i = 0; i < 3; i++) begin
            step_m(1'b0, rdy);
            checks++; if ({m_r, m_g, m_b} !== 16'hF81F || m_de !== 1'b1) begin failures++; $display("FAIL under_fill%0d: got %h de=%b want f81f de=1", i, {m_r, m_g, m_b}, m_de); end
        end
        step_m(1'b1, rdy);
        checks++; if ({m_r, m_g, m_b} !== pix(37)) begin failures++; $display("FAIL under_resume: got %h want %h", {m_r, m_g, m_b}, pix(37)); end
        checks++; if (m_under !== 16'd3) begin failures++; $display("FAIL under_cnt: got %0d want 3", m_under); end
        checks++; if (m_locked !== 1'b1 || m_desync !== 8'd0) begin failures++; $display("FAIL under_lock: got locked=%b desync=%0d want 1 0", m_locked, m_desync); end
    endtask

    task automatic test_early_sof();
        bit rdy;
        int acc = 0;
        lock_m();
        while (cyc < 355) step_m(1'b1, rdy);    // next edge is frame 1, v=5, h=10
        mk = 960;
        step_m(1'b1, rdy);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL sof_early_ready: got %b want 0", rdy); end
        checks++; if ({m_r, m_g, m_b} !== 16'hF81F) begin failures++; $display("FAIL sof_early_fill: got %h want f81f", {m_r, m_g, m_b}); end
        checks++; if (m_desync !== 8'd1 || m_locked !== 1'b0) begin failures++; $display("FAIL sof_early_desync: got desync=%0d locked=%b want 1 0", m_desync, m_locked); end
        while (cyc < 460) begin
            step_m(1'b1, rdy);
            if (rdy) acc++;
        end
        checks++; if (acc != 0) begin failures++; $display("FAIL armed_consumed: got %0d want 0", acc); end
        step_m(1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL relock_ready: got %b want 1", rdy); end
        checks++; if ({m_r, m_g, m_b} !== pix(960) || m_de !== 1'b1) begin failures++; $display("FAIL relock_pix: got %h de=%b want %h de=1", {m_r, m_g, m_b}, m_de, pix(960)); end
        checks++; if (m_locked !== 1'b1 || m_under !== 16'd0) begin failures++; $display("FAIL relock_state: got locked=%b under=%0d want 1 0", m_locked, m_under); end
    endtask

    task automatic test_reset_midline();
        bit rdy;
        while (cyc < 465) step_m(1'b1, rdy);    // last edge showed frame 2, v=0, h=4
        checks++; if (m_de !== 1'b1 || {m_r, m_g, m_b} !== pix(964)) begin failures++; $display("FAIL pre_reset_pix: got %h de=%b want %h de=1", {m_r, m_g, m_b}, m_de, pix(964)); end
        #2;
        m_valid = 1'b1; m_sof = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if ({m_r, m_g, m_b} !== 16'h0 || m_de !== 1'b0) begin failures++; $display("FAIL midreset_pix: got %h de=%b want 0000 0", {m_r, m_g, m_b}, m_de); end
        checks++; if (m_hs !== 1'b1 || m_vs !== 1'b1 || m_locked !== 1'b0) begin failures++; $display("FAIL midreset_sync: got hs=%b vs=%b locked=%b want 1 1 0", m_hs, m_vs, m_locked); end
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %b want 0", m_ready); end
        checks++; if (m_desync !== 8'd0 || m_under !== 16'd0) begin failures++; $display("FAIL midreset_cnt: got %0d/%0d want 0/0", m_desync, m_under); end
        m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_small_wrap();
        bit rdy;
        int beats1 = 0, bad_hs = 0, bad_vs = 0, bad_px = 0;
        do_reset();
        tk = 0;
        for (int c = 0; c < 96; c++) begin
            int p, h, v, fr;
            bit e_de;
            p = c % 48; h = p % 8; v = p / 8; fr = c / 48;
            step_t(1'b1, rdy);
            if (rdy && fr == 1) beats1++;
            e_de = (fr == 1) && (h < 4) && (v < 3);
            if (t_hs !== !(h >= 5 && h < 7)) bad_hs++;
            if (t_vs !== (v == 4)) bad_vs++;
            if (t_de !== e_de || {t_r, t_g, t_b} !== (e_de ? pix(v * 4 + h) : 16'h0)) bad_px++;
        end
        checks++; if (bad_hs != 0 || bad_vs != 0) begin failures++; $display("FAIL small_sync_wrap: bad hs=%0d vs=%0d want 0 0", bad_hs, bad_vs); end
        checks++; if (bad_px != 0) begin failures++; $display("FAIL small_pixels: bad_cycles=%0d want 0", bad_px); end
        checks++; if (beats1 != 12) begin failures++; $display("FAIL small_beats: got %0d want 12", beats1); end
        tk = 13;                                 // non-SOF beat arrives at (0,0)
        step_t(1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL nonsof_ready: got %b want 1", rdy); end
        checks++; if ({t_r, t_g, t_b} !== 16'h07E0) begin failures++; $display("FAIL nonsof_fill: got %h want 07e0", {t_r, t_g, t_b}); end
        checks++; if (t_desync !== 8'd1 || t_locked !== 1'b0) begin failures++; $display("FAIL nonsof_desync: got desync=%0d locked=%b want 1 0", t_desync, t_locked); end
        step_t(1'b1, rdy);
        checks++; if (rdy !== 1'b1 || t_de !== 1'b0 || {t_r, t_g, t_b} !== 16'h0) begin failures++; $display("FAIL seek_drop: got rdy=%b de=%b rgb=%h want 1 0 0000", rdy, t_de, {t_r, t_g, t_b}); end
        t_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int ucount = 0;
        do_reset();
        l_valid = 1'b1; l_sof = 1'b1; l_data = 16'hABCD;
        while (cyc < 4489) tick();
        #1;
        checks++; if (l_ready !== 1'b1) begin failures++; $display("FAIL sat_lock_ready: got %b want 1", l_ready); end
        tick();
        l_valid = 1'b0; l_sof = 1'b0;
        checks++; if (l_locked !== 1'b1 || {l_r, l_g, l_b} !== 16'hABCD) begin failures++; $display("FAIL sat_lock: got locked=%b rgb=%h want 1 abcd", l_locked, {l_r, l_g, l_b}); end
        while (ucount < 65540 && cyc < 90000) begin
            int p;
            bit act;
            p = cyc % 4489;
            act = ((p % 67) < 64) && ((p / 67) < 64);
            tick();
            if (act) begin
                ucount++;
                if (ucount == 1000) begin
                    checks++; if (l_under !== 16'd1000) begin failures++; $display("FAIL sat_cnt_1000: got %0d want 1000", l_under); end
                end
                if (ucount == 65534) begin
                    checks++; if (l_under !== 16'd65534) begin failures++; $display("FAIL sat_cnt_65534: got %0d want 65534", l_under); end
                end
                if (ucount == 65535) begin
                    checks++; if (l_under !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt_65535: got %h want ffff", l_under); end
                end
            end
        end
        checks++; if (ucount != 65540) begin failures++; $display("FAIL sat_budget: underflows=%0d want 65540", ucount); end
        checks++; if (l_under !== 16'hFFFF || l_locked !== 1'b1) begin failures++; $display("FAIL sat_hold: got %h locked=%b want ffff 1", l_under, l_locked); end
    endtask

    initial begin
        m_data = '0; m_valid = 1'b0; m_sof = 1'b0;
        t_data = '0; t_valid = 1'b0; t_sof = 1'b0;
        l_data = '0; l_valid = 1'b0; l_sof = 1'b0;
        test_reset();
        test_stream_default();
        test_underflow();
        test_early_sof();
        test_reset_midline();
        test_small_wrap();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
